// File: rtl/predistort_merge_if.sv
// ============================================================================
//  Module      : predistort_merge_if
//  Description : Four-channel input stream and merged output stream bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface predistort_merge_if #(
    parameter int WIDTH = 16
);
    logic [4*WIDTH-1:0] i_tdata;
    logic [3:0]         i_tlast;
    logic [3:0]         i_tvalid;
    logic [3:0]         i_tready;
    logic [WIDTH-1:0]   o_tdata;
    logic [1:0]         o_tuser;
    logic               o_tlast;
    logic               o_tvalid;
    logic               o_tready;

    // Merge block side
    modport slave (
        input  i_tdata, i_tlast, i_tvalid,
        output i_tready,
        output o_tdata, o_tuser, o_tlast, o_tvalid,
        input  o_tready
    );

    // Traffic source / sink side
    modport master (
        output i_tdata, i_tlast, i_tvalid,
        input  i_tready,
        input  o_tdata, o_tuser, o_tlast, o_tvalid,
        output o_tready
    );
endinterface

`default_nettype wire

// File: rtl/predistort_merge.sv
// ============================================================================
//  Module      : predistort_merge
//  Description : Packet-granular round-robin 4:1 stream merge with a
//                registered output stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module predistort_merge #(
    parameter int         WIDTH       = 16,
    parameter logic [3:0] ACTIVE_MASK = 4'b1111
) (
    input  wire logic            clk,
    input  wire logic            reset_n,
    input  wire logic            clear,
    predistort_merge_if.slave    bus
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PASS = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_ptr;
    logic [1:0]       r_grant;
    logic [WIDTH-1:0] r_tdata;
    logic [1:0]       r_tuser;
    logic             r_tlast;
    logic             r_tvalid;

    logic [3:0]       w_elig;
    logic [1:0]       w_pick;
    logic [1:0]       w_idx;
    logic             w_found;
    logic             w_out_free;
    logic             w_accept;
    logic             w_cur_last;
    logic [WIDTH-1:0] w_chan_data [4];

    for (genvar n = 0; n < 4; n++) begin : g_chan
        assign w_chan_data[n] = bus.i_tdata[n*WIDTH +: WIDTH];
    end

    assign w_elig     = bus.i_tvalid & ACTIVE_MASK;
    assign w_out_free = ~r_tvalid | bus.o_tready;
    assign w_accept   = (r_state == PASS) & bus.i_tvalid[r_grant] & w_out_free;
    assign w_cur_last = bus.i_tlast[r_grant];

    // Round-robin search from r_ptr; descending loop lets the nearest hit win.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_ptr;
        w_idx   = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            w_idx = r_ptr + 2'(k);
            if (w_elig[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        bus.i_tready = 4'b0000;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = PASS;
                end
            end
            PASS: begin
                if (w_out_free) begin
                    bus.i_tready[r_grant] = 1'b1;
                end
                if (w_accept && w_cur_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_ptr    <= 2'd0;
            r_grant  <= 2'd0;
            r_tdata  <= '0;
            r_tuser  <= 2'd0;
            r_tlast  <= 1'b0;
            r_tvalid <= 1'b0;
        end else if (clear) begin
            // Clear wins over a beat accepted on the same edge; that beat is dropped.
            r_state  <= IDLE;
            r_ptr    <= 2'd0;
            r_grant  <= 2'd0;
            r_tdata  <= '0;
            r_tuser  <= 2'd0;
            r_tlast  <= 1'b0;
            r_tvalid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == IDLE) && w_found) begin
                r_grant <= w_pick;
            end
            if (w_accept && w_cur_last) begin
                r_ptr <= r_grant + 2'd1;
            end
            if (w_accept) begin
                r_tdata  <= w_chan_data[r_grant];
                r_tuser  <= r_grant;
                r_tlast  <= w_cur_last;
                r_tvalid <= 1'b1;
            end else if (bus.o_tready) begin
                r_tvalid <= 1'b0;
            end
        end
    end

    assign bus.o_tdata  = r_tdata;
    assign bus.o_tuser  = r_tuser;
    assign bus.o_tlast  = r_tlast;
    assign bus.o_tvalid = r_tvalid;

endmodule

`default_nettype wire

// File: tb/tb_predistort_merge.sv
// ============================================================================
//  Module      : tb_predistort_merge
//  Description : Self-checking bench for the 4:1 packet merge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_predistort_merge;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic clear   = 1'b0;

    always #5 clk = ~clk;

    predistort_merge_if #(.WIDTH(16)) bus ();
    predistort_merge_if #(.WIDTH(16)) bm  ();
    predistort_merge_if #(.WIDTH(16)) bz  ();

    predistort_merge #(.WIDTH(16), .ACTIVE_MASK(4'b1111)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear), .bus(bus));
    predistort_merge #(.WIDTH(16), .ACTIVE_MASK(4'b0101)) dut_m (
        .clk(clk), .reset_n(reset_n), .clear(clear), .bus(bm));
    predistort_merge #(.WIDTH(16), .ACTIVE_MASK(4'b0000)) dut_z (
        .clk(clk), .reset_n(reset_n), .clear(clear), .bus(bz));

    // Masked instances see every channel permanently valid with single-beat packets
    assign bm.i_tdata  = bus.i_tdata;
    assign bm.i_tvalid = 4'hF;
    assign bm.i_tlast  = 4'hF;
    assign bm.o_tready = bus.o_tready;
    assign bz.i_tdata  = bus.i_tdata;
    assign bz.i_tvalid = 4'hF;
    assign bz.i_tlast  = 4'hF;
    assign bz.o_tready = bus.o_tready;

    typedef struct packed {
        logic [1:0]  user;
        logic [15:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        logic        rdy_in;
        logic        exp_valid;
        logic [15:0] exp_data;
        logic [1:0]  exp_user;
        logic        exp_last;
        logic [3:0]  exp_rdy;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    vec_t        tbl [17];
    logic [15:0] q_data [4][$];
    bit          q_last [4][$];
    bit          first_beat [4];
    int          pop_cnt [4];
    beat_t       exp_q [$];
    bit          ot_pat [$];
    bit          gap_en, rnd_ready, sb_on, mask_on;
    int          m_last_user;
    logic        s_ovalid, s_olast, s_otready;
    logic [15:0] s_odata;
    logic [1:0]  s_ouser;
    logic [3:0]  s_irdy;
    logic        p_stalled;
    logic [18:0] p_word;
    int          plen [4][3];
    logic [15:0] pdat [4][3][5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int n = 0; n < 4; n++) begin
            if (q_data[n].size() > 0) begin
                bus.i_tvalid[n] = !(gap_en && !first_beat[n] && ($urandom_range(2) == 0));
                bus.i_tdata[n*16 +: 16] = q_data[n][0];
                bus.i_tlast[n] = q_last[n][0];
            end else begin
                bus.i_tvalid[n] = 1'b0;
                bus.i_tdata[n*16 +: 16] = 16'h0;
                bus.i_tlast[n] = 1'b0;
            end
        end
        if (ot_pat.size() > 0) bus.o_tready = ot_pat.pop_front();
        else if (rnd_ready)    bus.o_tready = ($urandom_range(3) != 0);
        else                   bus.o_tready = 1'b1;
    endtask

    // One clock: drive, sample mid-cycle, check, then consume accepted source beats
    task automatic cycle();
        logic [3:0] hs;
        beat_t      e;
        drive();
        #3;
        s_ovalid  = bus.o_tvalid;
        s_odata   = bus.o_tdata;
        s_ouser   = bus.o_tuser;
        s_olast   = bus.o_tlast;
        s_otready = bus.o_tready;
        s_irdy    = bus.i_tready;
        hs        = bus.i_tvalid & bus.i_tready;
        if (p_stalled) begin
            chk("hold_valid", 32'(s_ovalid), 32'd1);
            chk("hold_beat", 32'({s_ouser, s_olast, s_odata}), 32'(p_word));
        end
        if (s_ovalid && !s_otready) chk("stall_ready", 32'(s_irdy), 32'd0);
        chk("ready_onehot", 32'($countones(s_irdy) <= 1), 32'd1);
        if (mask_on) begin
            chk("mask_ready13", 32'({bm.i_tready[3], bm.i_tready[1]}), 32'd0);
            chk("zero_mask", 32'({bz.o_tvalid, bz.i_tready}), 32'd0);
            if (bm.o_tvalid && bm.o_tready) begin
                chk("mask_alt", 32'(bm.o_tuser), (m_last_user == 0) ? 32'd2 : 32'd0);
                m_last_user = int'(bm.o_tuser);
            end
        end
        if (sb_on && s_ovalid && s_otready) begin
            if (exp_q.size() == 0) begin
                chk("extra_beat", 32'({s_ouser, s_olast, s_odata}), 32'h7FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("out_beat", 32'({s_ouser, s_olast, s_odata}), 32'({e.user, e.last, e.data}));
            end
        end
        p_stalled = s_ovalid && !s_otready && !clear;
        p_word    = {s_ouser, s_olast, s_odata};
        @(posedge clk);
        #1;
        for (int n = 0; n < 4; n++) begin
            if (hs[n] && q_data[n].size() > 0) begin
                void'(q_data[n].pop_front());
                first_beat[n] = q_last[n].pop_front();
                pop_cnt[n]++;
            end
        end
    endtask

    task automatic load_pkt(input int ch, input int len, input logic [15:0] base, input bit to_exp);
        for (int b = 0; b < len; b++) begin
            q_data[ch].push_back(base + 16'(b));
            q_last[ch].push_back(b == len - 1);
            if (to_exp) exp_q.push_back('{user: 2'(ch), data: base + 16'(b), last: (b == len - 1)});
        end
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        for (int n = 0; n < 4; n++) begin
            q_data[n].delete();
            q_last[n].delete();
            first_beat[n] = 1'b1;
            pop_cnt[n] = 0;
        end
        exp_q.delete();
        ot_pat.delete();
        p_stalled = 1'b0;
        gap_en = 1'b0;
        rnd_ready = 1'b0;
        bus.i_tvalid = 4'h0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic run_until(input int budget);
        int cyc = 0;
        while ((exp_q.size() > 0 || q_data[0].size() > 0 || q_data[1].size() > 0 ||
                q_data[2].size() > 0 || q_data[3].size() > 0) && cyc < budget) begin
            cycle();
            cyc++;
        end
        chk("drain_exp", 32'(exp_q.size()), 32'd0);
        chk("drain_src", 32'(q_data[0].size() + q_data[1].size() + q_data[2].size() + q_data[3].size()), 32'd0);
        for (int i = 0; i < 3; i++) cycle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int ptr, c, cyc;
        int rem [4];
        int pidx [4];

        // Table: 4 channels x 3-beat packets, o_tready held high, cycle-exact view
        tbl[0] = '{1'b1, 1'b0, 16'h0, 2'd0, 1'b0, 4'b0000};
        for (int p = 0; p < 4; p++) begin
            tbl[1 + 4*p] = '{1'b1, 1'b0, 16'h0, 2'd0, 1'b0, 4'(1 << p)};
            for (int b = 1; b <= 3; b++)
                tbl[1 + 4*p + b] = '{1'b1, 1'b1, 16'((p << 8) | b), 2'(p), (b == 3),
                                     (b < 3) ? 4'(1 << p) : 4'b0000};
        end

        sb_on = 1'b0; mask_on = 1'b0; m_last_user = -1;
        gap_en = 1'b0; rnd_ready = 1'b0; p_stalled = 1'b0;
        bus.i_tdata = '0; bus.i_tlast = 4'h0; bus.i_tvalid = 4'hF; bus.o_tready = 1'b1;

        @(posedge clk);
        #1;
        chk("rst_ovalid", 32'(bus.o_tvalid), 32'd0);
        chk("rst_odata", 32'(bus.o_tdata), 32'd0);
        chk("rst_ouser_olast", 32'({bus.o_tuser, bus.o_tlast}), 32'd0);
        chk("rst_iready", 32'(bus.i_tready), 32'd0);

        apply_reset();
        for (int n = 0; n < 4; n++) load_pkt(n, 3, 16'((n << 8) | 1), 1'b0);
        for (int k = 0; k < 17; k++) begin
            ot_pat.push_back(tbl[k].rdy_in);
            cycle();
            chk($sformatf("tbl%0d_valid", k), 32'(s_ovalid), 32'(tbl[k].exp_valid));
            chk($sformatf("tbl%0d_ready", k), 32'(s_irdy), 32'(tbl[k].exp_rdy));
            if (tbl[k].exp_valid)
                chk($sformatf("tbl%0d_beat", k), 32'({s_ouser, s_olast, s_odata}),
                    32'({tbl[k].exp_user, tbl[k].exp_last, tbl[k].exp_data}));
        end

        // ch2 5-beat packet; ch0 and ch1 arrive mid-packet, ch0 must follow
        apply_reset();
        sb_on = 1'b1;
        load_pkt(2, 5, 16'h2200, 1'b1);
        cyc = 0;
        while (pop_cnt[2] < 2 && cyc < 20) begin cycle(); cyc++; end
        chk("ch2_beat2_reached", 32'(pop_cnt[2] >= 2), 32'd1);
        load_pkt(0, 2, 16'h0A00, 1'b1);
        load_pkt(1, 3, 16'h1B00, 1'b1);
        run_until(100);

        // Output stall pattern 1,0,0,1 inside a 4-beat packet
        apply_reset();
        load_pkt(0, 4, 16'h0C10, 1'b1);
        cyc = 0;
        while (!s_ovalid && cyc < 10) begin cycle(); cyc++; end
        chk("stall_first_out", 32'(s_ovalid), 32'd1);
        ot_pat.push_back(1'b1); ot_pat.push_back(1'b0);
        ot_pat.push_back(1'b0); ot_pat.push_back(1'b1);
        run_until(100);

        // clear at beat 2 of a 4-beat ch1 packet
        apply_reset();
        load_pkt(1, 1, 16'h1100, 1'b1);
        q_last[1][0] = 1'b0;
        exp_q[0].last = 1'b0;
        q_data[1].push_back(16'h1101); q_last[1].push_back(1'b0);
        cyc = 0;
        while (pop_cnt[1] < 1 && cyc < 10) begin cycle(); cyc++; end
        load_pkt(1, 2, 16'h1102, 1'b0);
        load_pkt(0, 2, 16'h0D00, 1'b0);
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        chk("clear_beat_taken", 32'(pop_cnt[1]), 32'd2);
        cycle();
        chk("clear_ovalid", 32'(s_ovalid), 32'd0);
        chk("clear_idle_ready", 32'(s_irdy), 32'd0);
        for (int b = 0; b < 2; b++) exp_q.push_back('{user: 2'd0, data: 16'h0D00 + 16'(b), last: (b == 1)});
        for (int b = 0; b < 2; b++) exp_q.push_back('{user: 2'd1, data: 16'h1102 + 16'(b), last: (b == 1)});
        run_until(100);

        // Asynchronous reset mid-cycle with the output full
        apply_reset();
        load_pkt(3, 3, 16'h3300, 1'b1);
        cyc = 0;
        while (!s_ovalid && cyc < 10) begin cycle(); cyc++; end
        #3;
        chk("pre_async_valid", 32'(bus.o_tvalid), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus.o_tvalid), 32'd0);
        apply_reset();
        load_pkt(0, 2, 16'h0E00, 1'b1);
        run_until(100);

        // ACTIVE_MASK=0101 / 0000 instances, main merge under random back-pressure
        apply_reset();
        mask_on = 1'b1;
        m_last_user = -1;
        rnd_ready = 1'b1;
        for (int r = 0; r < 6; r++)
            for (int n = 0; n < 4; n++) load_pkt(n, 1, 16'((n << 12) | r), 1'b1);
        run_until(400);
        chk("mask_granted", 32'(m_last_user >= 0), 32'd1);
        mask_on = 1'b0;

        // Random packets, random gaps and back-pressure vs. round-robin packet order
        for (int rep = 0; rep < 4; rep++) begin
            apply_reset();
            gap_en = 1'b1;
            rnd_ready = 1'b1;
            for (int n = 0; n < 4; n++) begin
                rem[n] = 3;
                pidx[n] = 0;
                for (int p = 0; p < 3; p++) begin
                    plen[n][p] = int'($urandom_range(5, 1));
                    for (int b = 0; b < plen[n][p]; b++) begin
                        pdat[n][p][b] = 16'($urandom);
                        q_data[n].push_back(pdat[n][p][b]);
                        q_last[n].push_back(b == plen[n][p] - 1);
                    end
                end
            end
            ptr = 0;
            while (rem[0] + rem[1] + rem[2] + rem[3] > 0) begin
                c = -1;
                for (int k = 0; k < 4; k++)
                    if (c < 0 && rem[(ptr + k) % 4] > 0) c = (ptr + k) % 4;
                for (int b = 0; b < plen[c][pidx[c]]; b++)
                    exp_q.push_back('{user: 2'(c), data: pdat[c][pidx[c]][b],
                                      last: (b == plen[c][pidx[c]] - 1)});
                rem[c]--;
                pidx[c]++;
                ptr = (c + 1) % 4;
            end
            run_until(1500);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/predistort_merge.md
PREDISTORT_MERGE -- requirements
Module: predistort_merge

Interface
REQ-001: Parameter WIDTH, default 16, sample width of each input channel and of the output.
REQ-002: Parameter ACTIVE_MASK, 4 bits, default 4'b1111; bit n=1 makes channel n eligible for grant, and bit n=0 makes channel n permanently ignored.
REQ-003: clk  input  1  single clock; all logic on rising edge.
REQ-004: reset_n  input  1  asynchronous, active-low reset.
REQ-005: clear  input  1  synchronous clear; same effect as reset, applied on the clock edge.
REQ-006: i_tdata  input  4*WIDTH  channel n sample at bits [n*WIDTH +: WIDTH].
REQ-007: i_tlast  input  4  per-channel end-of-packet.
REQ-008: i_tvalid  input  4  per-channel valid.
REQ-009: i_tready  output  4  per-channel ready.
REQ-010: o_tdata  output  WIDTH  merged sample.
REQ-011: o_tuser  output  2  index of the source channel of the current o_tdata beat.
REQ-012: o_tlast  output  1  end of the merged packet; copied from the source beat.
REQ-013: o_tvalid  output  1  output valid.
REQ-014: o_tready  input  1  output ready.

Function
REQ-015: Packet-granular 4:1 merge, the inverse of the four-way channel split; one whole input packet is forwarded before another channel is served.
REQ-016: FSM states are IDLE and PASS.
REQ-017: In IDLE, select the first channel n that has i_tvalid[n]=1 and ACTIVE_MASK[n]=1, searching ptr, ptr+1, ... mod 4.
REQ-018: In IDLE, register that channel as grant and move to PASS on the next edge; no input beat is accepted in IDLE.
REQ-019: In IDLE with no eligible valid channel, remain in IDLE.
REQ-020: i_tready[n] = (state==PASS) & (grant==n) & (~o_tvalid | o_tready); all other i_tready bits are 0.
REQ-021: An accepted beat (i_tvalid[grant] & i_tready[grant]) loads the output register (o_tdata, o_tlast, o_tuser=grant) and sets o_tvalid=1 on the same edge.
REQ-022: Output latency is 1 cycle from acceptance to o_tvalid.
REQ-023: Sustained throughput is 1 beat/cycle while o_tready=1.
REQ-024: o_tvalid clears on o_tvalid & o_tready unless a new beat is loaded on that edge.
REQ-025: While o_tvalid=1 and o_tready=0, o_tdata, o_tuser and o_tlast are held stable (AXI rule).
REQ-026: An accepted beat with i_tlast=1 causes state<=IDLE and ptr<=(grant+1) mod 4 on the same edge.
REQ-027: The minimum gap between merged packets is one idle cycle, used for arbitration.
REQ-028: Packets are never interleaved; o_tuser is constant from the first beat to the o_tlast beat of a packet.
REQ-029: Single-beat packets (tlast on the first beat) are legal and give a grant of exactly one accepted beat.
REQ-030: A channel deasserting i_tvalid mid-packet stalls the merge in PASS; other channels are not served.
REQ-031: ACTIVE_MASK=4'b0000 leaves the block permanently in IDLE with all i_tready=0 and o_tvalid=0.
REQ-032: clear or reset asserted mid-packet abandons the packet: state=IDLE, ptr=0, o_tvalid=0.
REQ-033: After clear or reset, the remaining beats of an abandoned packet are treated as a new packet when next granted.
REQ-034: clear asserted in the same cycle as an accepted beat takes priority; that beat is not output.

Reset
REQ-035: While reset_n=0: state=IDLE, ptr=0, grant=0, o_tvalid=0, o_tlast=0, o_tdata=0, o_tuser=0, i_tready=4'b0000.
REQ-036: Reset release requires no synchronous preamble; arbitration is possible on the first edge after reset_n rises.

Verification
REQ-037: All four channels hold 3-beat packets (data 16'h0n01..0n03) valid from reset, o_tready=1 -> output order ch0,ch1,ch2,ch3 with correct o_tuser, tlast on every 3rd beat, one idle cycle between packets.
REQ-038: ch2 sends one 5-beat packet while ch1 becomes valid at its beat 2 -> all 5 ch2 beats are output contiguously before ch1; the next grant is ch3 if valid, else ch0, else ch1.
REQ-039: o_tready toggles 1,0,0,1 during a packet -> no beat is lost or duplicated, o_tdata is stable while stalled, and i_tready[grant]=0 while the output is full and stalled.
REQ-040: ACTIVE_MASK=4'b0101 with all channels valid -> only ch0 and ch2 are ever granted, alternately; i_tready[1] and i_tready[3] stay 0.
REQ-041: clear pulsed at beat 2 of a 4-beat ch1 packet -> o_tvalid=0 next cycle, ptr=0; if ch0 is valid it is granted next.
REQ-042: reset_n asserted asynchronously mid-cycle while o_tvalid=1 -> o_tvalid=0 immediately without waiting for a clock edge; normal operation resumes after release.
